// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
//   Multi-channel LED pattern generator. A debounced button press steps the
//   mode OFF -> ON -> BLINK -> BREATHE -> OFF. Reset lands in BLINK.
//
//   Compile-time option:
//     LEDGEN_DEBOUNCE_EN  defined   : counter-based debounce on the button.
//                         undefined : the synchronised button is used directly.
//                                     DEBOUNCE_CYCLES has no effect.
//
//   Ports:
//     clk     in   fabric clock
//     rst     in   synchronous, active-high reset
//     button  in   raw asynchronous button level, high = pressed
//     led     out  [CHANNELS-1:0] LED drive, high = lit, registered
//     mode    out  [1:0] current mode (0 OFF, 1 ON, 2 BLINK, 3 BREATHE),
//                  registered; this is also the mode FSM state
//
//   No valid/ready handshakes: the only input is a level, sampled every clk.
// ---------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int CHANNELS        = 3,
  parameter int CNT_W           = 24,
  parameter int HALF_PERIOD     = 4000000,
  parameter int PWM_W           = 8,
  parameter int BREATHE_STEP    = 16384,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button,
  output logic [CHANNELS-1:0] led,
  output logic [1:0]          mode
);

  // Elaboration-time parameter range guards.
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("led_pattern_gen: CHANNELS must be 1..8");
  end
  if (HALF_PERIOD < 2) begin : g_bad_half_period
    $error("led_pattern_gen: HALF_PERIOD must be >= 2");
  end
  if (BREATHE_STEP < 1) begin : g_bad_breathe_step
    $error("led_pattern_gen: BREATHE_STEP must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("led_pattern_gen: DEBOUNCE_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam int                 STEP_W     = (BREATHE_STEP > 1) ? $clog2(BREATHE_STEP) : 1;
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(BREATHE_STEP - 1);
  localparam logic [CNT_W-1:0]   BLINK_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [PWM_W-1:0]   DUTY_MAX   = '1;

  // -------------------------------------------------------------------------
  // Button path: 2-FF synchroniser, optional debounce, rising-edge press.
  // -------------------------------------------------------------------------
  logic sync_0;
  logic btn_s;
  logic btn_d;
  logic press;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_0 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_0 <= button;
      btn_s  <= sync_0;
    end
  end

`ifdef LEDGEN_DEBOUNCE_EN
  localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt;
  logic            btn_d_q;

  // db_cnt counts consecutive cycles of disagreement; any agreement restarts
  // it, so a glitch shorter than DEBOUNCE_CYCLES never reaches btn_d.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt  <= '0;
      btn_d   <= 1'b0;
      btn_d_q <= 1'b0;
    end else begin
      btn_d_q <= btn_d;
      if (btn_s == btn_d) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_d  <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = btn_d & ~btn_d_q;
`else
  // Press is taken on the same edge that btn_d picks up the new level, which
  // gives a 3-edge button-to-mode latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_d <= 1'b0;
    end else begin
      btn_d <= btn_s;
    end
  end

  assign press = btn_s & ~btn_d;
`endif

  // -------------------------------------------------------------------------
  // Mode FSM and pattern state.
  // -------------------------------------------------------------------------
  mode_t              mode_q;
  logic [CNT_W-1:0]   blink_cnt;
  logic               phase;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [PWM_W-1:0]   duty;
  logic               dir_down;
  logic [STEP_W-1:0]  step_cnt;
  logic [CHANNELS-1:0] led_next;

  assign mode = mode_q;

  // led is computed from the current (pre-edge) mode and pattern state, so it
  // trails them by one cycle.
  always_comb begin
    led_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode_q)
        MODE_ON:      led_next[i] = 1'b1;
        MODE_BLINK:   led_next[i] = phase ^ i[0];
        MODE_BREATHE: led_next[i] = i[0] ? (pwm_cnt < (DUTY_MAX - duty))
                                         : (pwm_cnt < duty);
        default:      led_next[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_BLINK;
      led       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      pwm_cnt   <= '0;
      duty      <= '0;
      dir_down  <= 1'b0;
      step_cnt  <= '0;
    end else begin
      led <= led_next;

      // Default: every pattern register is cleared; the active mode's branch
      // below overrides the ones it uses. A press wins over any wrap.
      blink_cnt <= '0;
      phase     <= 1'b0;
      pwm_cnt   <= '0;
      duty      <= '0;
      dir_down  <= 1'b0;
      step_cnt  <= '0;

      if (press) begin
        mode_q <= mode_t'(mode_q + 2'd1);
      end else begin
        case (mode_q)
          MODE_BLINK: begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              phase     <= ~phase;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
              phase     <= phase;
            end
          end
          MODE_BREATHE: begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            duty     <= duty;
            dir_down <= dir_down;
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              // Direction flips on the step that reaches an endpoint, so each
              // endpoint value is held for exactly one step.
              if (!dir_down) begin
                duty <= duty + 1'b1;
                if (duty == DUTY_MAX - 1'b1) dir_down <= 1'b1;
              end else begin
                duty <= duty - 1'b1;
                if (duty == PWM_W'(1)) dir_down <= 1'b0;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
//   Self-checking bench for led_pattern_gen. A reference model derives the
//   expected mode and led from the number of cycles spent in the current mode
//   (blink phase, PWM position and triangle-wave duty by arithmetic) and from
//   a sliding window of synchronised button samples. Expected values go
//   through exp_q and are compared one cycle at a time, plus directed checks
//   of latency and of fixed values at points of interest.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int CHANNELS        = 2;
  localparam int CNT_W           = 8;
  localparam int HALF_PERIOD     = 4;
  localparam int PWM_W           = 3;
  localparam int BREATHE_STEP    = 2;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int DUTY_MAX        = (1 << PWM_W) - 1;

`ifdef LEDGEN_DEBOUNCE_EN
  localparam int PRESS_LAT   = DEBOUNCE_CYCLES + 3;
  localparam int GLITCH_MODE = 3;   // glitches filtered, stays in BREATHE
`else
  localparam int PRESS_LAT   = 3;
  localparam int GLITCH_MODE = 1;   // each 5-cycle pulse is a press: 3->0->1
`endif

  // ---------------- clock / reset ----------------
  logic                clk    = 1'b0;
  logic                rst    = 1'b1;
  logic                button = 1'b0;
  logic [CHANNELS-1:0] led;
  logic [1:0]          mode;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .CHANNELS        (CHANNELS),
    .CNT_W           (CNT_W),
    .HALF_PERIOD     (HALF_PERIOD),
    .PWM_W           (PWM_W),
    .BREATHE_STEP    (BREATHE_STEP),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .led    (led),
    .mode   (mode)
  );

  // ---------------- scoreboard ----------------
  int                  checks = 0;
  int                  errors = 0;
  string               phase_name = "reset";
  logic [CHANNELS+1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]          m_mode = 2'd2;
  int                  m_k    = 0;     // cycles since entering current mode
  logic [CHANNELS-1:0] m_led  = '0;
  bit                  m_sync0, m_sync1;
  bit                  m_acc, m_rose;
  bit                  m_hist[$];

  // Triangle wave 0..DUTY_MAX..0 with one step per endpoint.
  function automatic int tri_duty(input int j);
    int t;
    t = j % (2 * DUTY_MAX);
    return (t <= DUTY_MAX) ? t : (2 * DUTY_MAX - t);
  endfunction

  function automatic logic [CHANNELS-1:0] pattern(input logic [1:0] md, input int k);
    logic [CHANNELS-1:0] p;
    int pwm, duty, ph;
    p    = '0;
    pwm  = k % (DUTY_MAX + 1);
    duty = tri_duty(k / BREATHE_STEP);
    ph   = (k / HALF_PERIOD) % 2;
    for (int i = 0; i < CHANNELS; i++) begin
      case (md)
        2'd1:    p[i] = 1'b1;
        2'd2:    p[i] = (((ph + i) % 2) == 1);
        2'd3:    p[i] = ((i % 2) == 0) ? (pwm < duty) : (pwm < (DUTY_MAX - duty));
        default: p[i] = 1'b0;
      endcase
    end
    return p;
  endfunction

  task automatic model_edge(input bit b, input bit r);
    bit bs, press, all_diff;
    if (r) begin
      m_mode = 2'd2; m_k = 0; m_led = '0;
      m_sync0 = 0; m_sync1 = 0; m_acc = 0; m_rose = 0;
      m_hist.delete();
    end else begin
      m_led = pattern(m_mode, m_k);
      bs    = m_sync1;
`ifdef LEDGEN_DEBOUNCE_EN
      // Accepted level flips once the last DEBOUNCE_CYCLES synchronised
      // samples all disagree with it; a press is seen one edge later.
      press  = m_rose;
      m_rose = 0;
      m_hist.push_back(bs);
      if (m_hist.size() > DEBOUNCE_CYCLES) void'(m_hist.pop_front());
      if (m_hist.size() == DEBOUNCE_CYCLES) begin
        all_diff = 1;
        foreach (m_hist[j]) if (m_hist[j] == m_acc) all_diff = 0;
        if (all_diff) begin
          m_acc  = ~m_acc;
          m_rose = m_acc;
        end
      end
`else
      all_diff = 0;
      press    = bs & ~m_acc;
      m_acc    = bs;
`endif
      if (press) begin
        m_mode = m_mode + 2'd1;
        m_k    = 0;
      end else begin
        m_k++;
      end
      m_sync1 = m_sync0;
      m_sync0 = b;
    end
    exp_q.push_back({m_mode, m_led});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic b, input logic r);
    logic [CHANNELS+1:0] e;
    button = b;
    rst    = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    e = exp_q.pop_front();
    check({phase_name, "_mode"}, mode, e[CHANNELS +: 2]);
    check({phase_name, "_led"}, led, e[CHANNELS-1:0]);
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  // Hold the button high until mode moves (bounded), check the latency, keep
  // holding to 20 cycles total, then release.
  task automatic press_and_release(input string name);
    logic [1:0] m0;
    int         n;
    bit         seen;
    m0 = mode; n = 0; seen = 0;
    phase_name = name;
    while (!seen && n < 40) begin
      step(1'b1, 1'b0);
      n++;
      if (mode != m0) seen = 1;
    end
    check({name, "_latency"}, n, PRESS_LAT);
    if (n < 20) run(1'b1, 20 - n);
    run(1'b0, 2 * DEBOUNCE_CYCLES + 6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n_press;
    logic [1:0] exp_mode;

    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check("reset_mode", mode, 2'd2);
    check("reset_led", led, 2'b00);

    // Blink after release: first led is phase 0 -> 2'b10.
    phase_name = "blink";
    step(1'b0, 1'b0);
    check("blink_first_led", led, 2'b10);
    run(1'b0, 19);

    // Long hold: exactly one press, BLINK -> BREATHE.
    press_and_release("hold");
    check("hold_mode", mode, 2'd3);

    // Bounce pattern.
    phase_name = "glitch";
    run(1'b1, 5); run(1'b0, 5); run(1'b1, 5); run(1'b0, 2 * DEBOUNCE_CYCLES + 6);
    check("glitch_mode", mode, GLITCH_MODE);

    // Cycle through all modes and end in BREATHE.
    exp_mode = 2'(GLITCH_MODE);
    n_press  = 4 + ((3 - GLITCH_MODE + 4) % 4);
    for (int i = 0; i < n_press; i++) begin
      press_and_release("cycle");
      exp_mode = exp_mode + 2'd1;
      check("cycle_mode", mode, exp_mode);
      if (exp_mode == 2'd0) check("cycle_off_led", led, 2'b00);
      if (exp_mode == 2'd1) check("cycle_on_led", led, 2'b11);
    end
    phase_name = "breathe";
    run(1'b0, 40);

    // Reset mid-breathe with the debounce counter at 5.
    phase_name = "rst_mid";
    run(1'b1, 7);
    step(1'b1, 1'b1);
    check("rst_mid_mode", mode, 2'd2);
    check("rst_mid_led", led, 2'b00);
    press_and_release("after_rst");
    check("after_rst_mode", mode, 2'd3);

    // Randomised button activity with occasional resets.
    phase_name = "rand";
    for (int s = 0; s < 40; s++) begin
      logic b;
      int   len;
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * DEBOUNCE_CYCLES + 4);
      for (int c = 0; c < len; c++) step(b, 1'($urandom_range(0, 149) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
